keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan sequencer and key-event generator for the 4x4 matrix keypad on the board. It drives one column low at a time, samples the row inputs after a settle interval, and assembles a 16-bit raw key map per frame. The map is debounced across frames, and each newly stable key press is reported as a single-cycle `key_valid` pulse with a 4-bit code. It replaces ad-hoc per-column polling and feeds the display/LED logic and any code-entry FSM above it.

## Interface
- `SETTLE_CYCLES`, default 1000: cycles each column is driven before its rows are sampled. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, default 250: consecutive identical frames required before the raw map is accepted. 250 frames is about 10 ms at 100 MHz. Must be ≥ 1.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `scan_en`, in, 1: 1 = scanning runs; 0 = scanning stops and state clears.
- `rows_in`, in, 4: keypad row lines, active-low; bit r low = key in row r pressed in the driven column. Asynchronous to `clk`.
- `cols_out`, out, 4: column drive, active-low, at most one bit low.
- `key_code`, out, 4: code of the reported key, `col*4 + row`. Valid while `key_valid`=1; otherwise holds its last value.
- `key_valid`, out, 1: one-cycle pulse per reported press.
- `key_held`, out, 1: 1 while any key is in the debounced map.
- `multi_key`, out, 1: 1 while two or more keys are in the debounced map.

## Operation
- `rows_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Column slots:
  - Slot c lasts exactly `SETTLE_CYCLES` cycles with `cols_out` = ~(1<<c).
  - On the last cycle of a slot, the inverted synchronized rows are written to `raw_next[c*4+3:c*4]` and c advances (3 wraps to 0).
  - The edge ending slot 3 is the frame end. A frame is 4*`SETTLE_CYCLES` cycles.
- FSM states: DRIVE (count the settle time), SAMPLE (one-cycle capture folded into the last DRIVE cycle), FRAME_END (debounce/report update on the same edge), DISABLED.
- Debounce at each frame end:
  - If `raw_next` equals `raw_prev`, `stable_cnt` increments, saturating at `DEBOUNCE_FRAMES`. Otherwise `stable_cnt` is set to 1.
  - `raw_prev` is then loaded with `raw_next`.
  - When `stable_cnt` reaches `DEBOUNCE_FRAMES` (after the update), `stable_map` is loaded with `raw_next`.
- Reporting:
  - `reported` is a 16-bit mask. A bit is cleared whenever its `stable_map` bit is 0.
  - At each frame end, pending = `stable_map & ~reported`, evaluated with post-update values.
  - If pending ≠ 0, the lowest set index i is reported: `key_code`=i, `key_valid`=1 on the following cycle, and `reported[i]` is set.
  - At most one report per frame. Remaining pending keys are reported in later frames in ascending index order.
- A key released (debounced) and pressed again (debounced) is reported again.
- `key_held` = (`stable_map` ≠ 0). `multi_key` = (popcount(`stable_map`) ≥ 2). Both are registered.
- `scan_en`=0, sampled at any edge and even mid-slot:
  - Next cycle: `cols_out`=1111.
  - Slot counter and column index go to 0.
  - `raw_next`, `raw_prev`, `stable_cnt`, `stable_map` and `reported` are cleared.
  - `key_valid` is 0, `key_held` and `multi_key` fall.
- `scan_en` rising: scanning restarts at column 0 with a full slot.
- No ghost-key suppression. Ghosted keys are reported as raw and flagged through `multi_key`.

## Timing
- Reset values: `cols_out`=1110, `key_code`=0, `key_valid`=0, `key_held`=0, `multi_key`=0. All maps, counters and synchronizer flops are 0. The slot counter is 0 with column 0 active.
- `rst` has priority over `scan_en`.
- `rst` mid-frame discards the partial frame. Scanning resumes from column 0 on the first cycle after `rst` drops (if `scan_en`=1).
- Press-to-report latency for a clean press: between `DEBOUNCE_FRAMES` and `DEBOUNCE_FRAMES`+1 frames, plus 1 cycle.
- Synchronizer latency is 2 cycles, which `SETTLE_CYCLES` ≥ 4 covers.
- `stable_cnt` width is clog2(`DEBOUNCE_FRAMES`+1). The slot counter width is clog2(`SETTLE_CYCLES`).

## Structure
- Shared package `keypad_pkg`:
  - `NUM_ROWS`=4 and `NUM_COLS`=4.
  - The FSM state enum.
  - `COL_IDLE`=4'b1111.
  - The column drive patterns 1110/1101/1011/0111.
  - The key-code typedef (4 bits).
- One sub-module, `keypad_debounce`:
  - Inputs: `raw_next`, frame-end strobe, clear.
  - Owns `raw_prev`, `stable_cnt`, `stable_map`, `reported` and the priority encoder.
  - Outputs: `key_code`, `key_valid`, `key_held`, `multi_key`.
- `keypad_scan_ctrl` keeps the synchronizer, slot counter and column drive.

## Test plan
- Reset with `SETTLE_CYCLES`=4 and `DEBOUNCE_FRAMES`=3:
  - All outputs are 0 and `cols_out`=1110.
  - After `rst` drops, `cols_out` is 1110 for 4 cycles, then 1101, 1011, 0111 for 4 cycles each, then 1110 again.
- Clean single press of row 1, col 2, held from before frame 1 with the model pulling `rows_in`[1] low while `cols_out`[2]=0:
  - Exactly one `key_valid`, with `key_code`=9, one cycle after the third frame end.
  - `key_held`=1 and `multi_key`=0.
  - Release for 3 frames: `key_held` falls.
  - Press again: a second pulse with code 9.
- Bounce, with the key toggling every frame for 10 frames: no `key_valid` and `key_held` stays 0.
- Codes 2 and 13 stable together:
  - Code 2 is reported after the third frame end.
  - Code 13 is reported after the fourth frame end.
  - `multi_key`=1. No further pulses while both are held.
- `scan_en` dropped mid-slot of column 2 while code 9 is held:
  - Next cycle: `cols_out`=1111 and `key_held`=0.
  - Re-enable: column 0 restarts, and code 9 is reported again after 3 frames.
- `rst` asserted at the frame-end edge of the debounce-completing frame: no `key_valid`, and the outputs return to their reset values.

Source files
------------

// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared keypad sizes, scan FSM states, column drive patterns and key-code type
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {DRIVE, SAMPLE, FRAME_END, DISABLED} scan_state_t;
  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] COL_DRIVE [NUM_COLS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  typedef logic [3:0] key_code_t;
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad bus (scan_en/rows_in in, cols_out/key_code/key_valid/key_held/multi_key out)
interface keypad_scan_ctrl_if;
  logic scan_en;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  keypad_pkg::key_code_t key_code;
  logic key_valid;
  logic key_held;
  logic multi_key;
  modport master(output scan_en, rows_in, input cols_out, key_code, key_valid, key_held, multi_key);
  modport slave(input scan_en, rows_in, output cols_out, key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scan_ctrl_debounce.sv
// keypad_debounce: frame-level debounce and lowest-index key reporting (raw_next/frame_end/clr in, key_code/key_valid/key_held/multi_key out)
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        frame_end,
  input  logic [15:0] raw_next,
  output key_code_t   key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        multi_key
);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] CMAX = SW'(DEBOUNCE_FRAMES);
  logic [15:0] raw_prev, stable_map, reported, map_n, rep_n, pend;
  logic [SW-1:0] stable_cnt, cnt_n;
  key_code_t idx;
  always_comb begin
    cnt_n = raw_next != raw_prev ? SW'(1) : stable_cnt == CMAX ? stable_cnt : stable_cnt + 1'b1;
    map_n = cnt_n == CMAX ? raw_next : stable_map;
    rep_n = reported & map_n;
    pend = map_n & ~rep_n;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (pend[i]) idx = key_code_t'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_prev <= '0;
      stable_cnt <= '0;
      stable_map <= '0;
      reported <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      multi_key <= 1'b0;
    end else if (clr) begin
      raw_prev <= '0;
      stable_cnt <= '0;
      stable_map <= '0;
      reported <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= frame_end && |pend;
      if (frame_end) begin
        raw_prev <= raw_next;
        stable_cnt <= cnt_n;
        stable_map <= map_n;
        reported <= rep_n | (|pend ? 16'd1 << idx : 16'd0);
        key_held <= |map_n;
        multi_key <= |(map_n & (map_n - 1'b1));
        if (|pend) key_code <= idx;
      end
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with row synchronizer (clk, rst, bus: keypad_scan_ctrl_if.slave)
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_FRAMES = 250
) (
  input logic clk,
  input logic rst,
  keypad_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  logic [NUM_ROWS-1:0] sync1, sync2;
  logic [CW-1:0] cnt;
  logic [1:0] col;
  logic [11:0] raw_lo;
  logic [3:0] cols;
  scan_state_t st;
  assign bus.cols_out = cols;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt <= '0;
      col <= '0;
      raw_lo <= '0;
      cols <= COL_DRIVE[0];
      st <= DRIVE;
    end else begin
      {sync2, sync1} <= {sync1, bus.rows_in};
      if (!bus.scan_en) begin
        cnt <= '0;
        col <= '0;
        raw_lo <= '0;
        cols <= COL_IDLE;
        st <= DISABLED;
      end else if (st == DISABLED) begin
        cols <= COL_DRIVE[0];
        st <= DRIVE;
      end else if (st == DRIVE) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(SETTLE_CYCLES - 2)) st <= col == 2'd3 ? FRAME_END : SAMPLE;
      end else begin
        cnt <= '0;
        col <= col + 1'b1;
        cols <= COL_DRIVE[col + 1'b1];
        st <= DRIVE;
        if (st == SAMPLE) raw_lo[{col, 2'b00} +: 4] <= ~sync2;
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk(clk),
    .rst(rst),
    .clr(!bus.scan_en),
    .frame_end(st == FRAME_END && bus.scan_en),
    .raw_next({~sync2, raw_lo}),
    .key_code(bus.key_code),
    .key_valid(bus.key_valid),
    .key_held(bus.key_held),
    .multi_key(bus.multi_key)
  );
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed and random keypad stimulus checked against a frame-level reference model
module tb_keypad_scan_ctrl;
  localparam int S = 4;
  localparam int D = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = '0;
  logic [15:0] cur = '0;
  logic [15:0] hist[$];
  logic [15:0] mmap, mrep;
  logic exp_valid, exp_held, exp_multi;
  logic [3:0] exp_code;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  keypad_scan_ctrl_if bus();
  keypad_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_FRAMES(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_comb begin
    bus.rows_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!bus.cols_out[c] && keys[c*4+r]) bus.rows_in[r] = 1'b0;
  end
  task check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task model_clear;
    hist.delete();
    mmap = '0;
    mrep = '0;
    exp_valid = 1'b0;
    exp_held = 1'b0;
    exp_multi = 1'b0;
    exp_code = '0;
  endtask
  task model_frame(input logic [15:0] m);
    logic stable;
    logic [15:0] pend;
    hist.push_back(m);
    if (hist.size() > D) void'(hist.pop_front());
    stable = hist.size() == D;
    foreach (hist[i]) if (hist[i] != m) stable = 1'b0;
    if (stable) mmap = m;
    mrep &= mmap;
    pend = mmap & ~mrep;
    exp_valid = pend != 0;
    for (int i = 0; i < 16; i++)
      if (pend[i]) begin
        exp_code = 4'(i);
        mrep[i] = 1'b1;
        break;
      end
    exp_held = mmap != 0;
    exp_multi = $countones(mmap) >= 2;
  endtask
  task step(input logic [15:0] m, input int n);
    logic [3:0] ec;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        check("key_valid", bus.key_valid, exp_valid);
        if (exp_valid) check("key_code", bus.key_code, exp_code);
        check("key_held", bus.key_held, exp_held);
        check("multi_key", bus.multi_key, exp_multi);
        exp_valid = 1'b0;
        keys = m;
      end else check("key_valid_idle", bus.key_valid, 1'b0);
      ec = ~(4'b0001 << (k / S));
      check("cols_out", bus.cols_out, ec);
      @(negedge clk);
    end
  endtask
  task run_frame(input logic [15:0] m);
    step(m, 4 * S);
    model_frame(m);
  endtask
  task check_reset_outputs;
    check("rst_cols", bus.cols_out, 4'b1110);
    check("rst_code", bus.key_code, 4'd0);
    check("rst_valid", bus.key_valid, 1'b0);
    check("rst_held", bus.key_held, 1'b0);
    check("rst_multi", bus.multi_key, 1'b0);
  endtask
  initial begin
    bus.scan_en = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (5) run_frame(16'h0200);
    repeat (4) run_frame(16'h0000);
    repeat (4) run_frame(16'h0200);
    step(16'h0200, 9);
    bus.scan_en = 1'b0;
    @(negedge clk);
    check("dis_cols", bus.cols_out, 4'b1111);
    check("dis_held", bus.key_held, 1'b0);
    check("dis_multi", bus.multi_key, 1'b0);
    check("dis_valid", bus.key_valid, 1'b0);
    bus.scan_en = 1'b1;
    @(negedge clk);
    model_clear();
    repeat (4) run_frame(16'h0200);
    repeat (4) run_frame(16'h0000);
    for (int i = 0; i < 10; i++) run_frame(i % 2 == 0 ? 16'h0200 : 16'h0000);
    repeat (6) run_frame(16'h2004);
    repeat (2) run_frame(16'h0020);
    step(16'h0020, 4 * S - 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_clear();
    cur = '0;
    repeat (30) begin
      if ($urandom_range(0, 2) == 0) cur = 16'($urandom & $urandom & $urandom);
      run_frame(cur);
    end
    run_frame(cur);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
